// File: rtl/sif_pkg.sv
// Shared types for the SIF access arbiter: per-port op codes, FSM states and
// requester identifiers, plus the strobe-to-op decoder.
package sif_pkg;

   typedef enum logic [1:0] {
      OP_IDLE    = 2'b00,
      OP_READ    = 2'b01,
      OP_WRITE   = 2'b10,
      OP_ILLEGAL = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RDWAIT = 2'b10,
      ST_ACK    = 2'b11
   } state_e;

   typedef enum logic {
      PORT_XA = 1'b0,
      PORT_WA = 1'b1
   } port_e;

   // Strobe pair {wr_s, rd_s} maps one-to-one onto the op encoding.
   function automatic op_e decode_op(input logic wr_s, input logic rd_s);
      return op_e'({wr_s, rd_s});
   endfunction

endpackage

// File: rtl/sif_rr_arb.sv
// Two-way round-robin selector. Holds the last-granted port and, on a tie,
// picks the other one; a lone requester wins outright.
module sif_rr_arb
   import sif_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       update,
   input  port_e      last,
   output port_e      grant
);

   port_e r_last;

   // WA counts as last-granted out of reset so XA wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last <= PORT_WA;
      end else if (update) begin
         r_last <= last;
      end
   end

   always_comb begin
      grant = PORT_XA;
      if (req == 2'b11) begin
         grant = (r_last == PORT_XA) ? PORT_WA : PORT_XA;
      end else if (req == 2'b10) begin
         grant = PORT_WA;
      end
   end

endmodule

// File: rtl/sif_access_arbiter.sv
// Arbitrates two strobe-style requesters (XA, WA) onto one shared memory with
// a one-cycle read latency; every transaction ends in a single-cycle ack.
module sif_access_arbiter
   import sif_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              xa_wr_s,
   input  logic              xa_rd_s,
   input  logic [ADDR_W-1:0] xa_addr,
   input  logic [DATA_W-1:0] xa_wdata,
   output logic [DATA_W-1:0] xa_rdata,
   output logic              xa_ack,
   output logic              xa_err,
   input  logic              wa_wr_s,
   input  logic              wa_rd_s,
   input  logic [ADDR_W-1:0] wa_addr,
   input  logic [DATA_W-1:0] wa_wdata,
   output logic [DATA_W-1:0] wa_rdata,
   output logic              wa_ack,
   output logic              wa_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   logic [1:0]        w_wr_s;
   logic [1:0]        w_rd_s;
   logic [ADDR_W-1:0] w_addr  [2];
   logic [DATA_W-1:0] w_wdata [2];
   op_e               w_op    [2];
   logic [1:0]        w_req;
   port_e             w_grant;
   op_e               w_gnt_op;
   logic              w_start;

   state_e            r_state;
   port_e             r_gnt;
   op_e               r_op;
   logic [1:0]        r_block;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata [2];
   logic              r_mem_en;
   logic              r_mem_we;
   logic [1:0]        r_ack;
   logic [1:0]        r_err;

   assign w_wr_s     = {wa_wr_s, xa_wr_s};
   assign w_rd_s     = {wa_rd_s, xa_rd_s};
   assign w_addr[0]  = xa_addr;
   assign w_addr[1]  = wa_addr;
   assign w_wdata[0] = xa_wdata;
   assign w_wdata[1] = wa_wdata;

   // r_block masks the port acked in the previous cycle, so a strobe still
   // held across the ack edge cannot start a duplicate transaction.
   for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign w_op[gi]  = decode_op(w_wr_s[gi], w_rd_s[gi]);
      assign w_req[gi] = (w_op[gi] != OP_IDLE) && !r_block[gi];
   end

   assign w_gnt_op = w_op[w_grant];
   assign w_start  = (r_state == ST_IDLE) && (w_req != 2'b00);

   sif_rr_arb u_rr_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (w_req),
      .update (w_start),
      .last   (w_grant),
      .grant  (w_grant)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_gnt      <= PORT_XA;
         r_op       <= OP_IDLE;
         r_block    <= 2'b00;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rdata[0] <= '0;
         r_rdata[1] <= '0;
         r_mem_en   <= 1'b0;
         r_mem_we   <= 1'b0;
         r_ack      <= 2'b00;
         r_err      <= 2'b00;
      end else begin
         r_block <= 2'b00;
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_gnt   <= w_grant;
                  r_op    <= w_gnt_op;
                  r_addr  <= w_addr[w_grant];
                  r_wdata <= w_wdata[w_grant];
                  if (w_gnt_op == OP_ILLEGAL) begin
                     r_state        <= ST_ACK;
                     r_ack[w_grant] <= 1'b1;
                     r_err[w_grant] <= 1'b1;
                  end else begin
                     r_state  <= ST_ACCESS;
                     r_mem_en <= 1'b1;
                     r_mem_we <= (w_gnt_op == OP_WRITE);
                  end
               end
            end
            ST_ACCESS: begin
               r_mem_en <= 1'b0;
               r_mem_we <= 1'b0;
               if (r_op == OP_WRITE) begin
                  r_state      <= ST_ACK;
                  r_ack[r_gnt] <= 1'b1;
               end else begin
                  r_state <= ST_RDWAIT;
               end
            end
            ST_RDWAIT: begin
               r_rdata[r_gnt] <= mem_rdata;
               r_ack[r_gnt]   <= 1'b1;
               r_state        <= ST_ACK;
            end
            ST_ACK: begin
               r_ack          <= 2'b00;
               r_err          <= 2'b00;
               r_block[r_gnt] <= 1'b1;
               r_state        <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign xa_rdata  = r_rdata[0];
   assign wa_rdata  = r_rdata[1];
   assign xa_ack    = r_ack[0];
   assign wa_ack    = r_ack[1];
   assign xa_err    = r_err[0];
   assign wa_err    = r_err[1];

endmodule

// File: tb/tb_sif_access_arbiter.sv
// Self-checking bench for sif_access_arbiter: directed vector table, hand
// sequences for round robin / held strobe / mid-read reset, then random traffic.
module tb_sif_access_arbiter;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              xa_wr_s, xa_rd_s, wa_wr_s, wa_rd_s;
   logic [ADDR_W-1:0] xa_addr, wa_addr, mem_addr;
   logic [DATA_W-1:0] xa_wdata, wa_wdata, xa_rdata, wa_rdata, mem_wdata, mem_rdata;
   logic              xa_ack, xa_err, wa_ack, wa_err, mem_en, mem_we;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sif_access_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s), .xa_addr(xa_addr), .xa_wdata(xa_wdata),
      .xa_rdata(xa_rdata), .xa_ack(xa_ack), .xa_err(xa_err),
      .wa_wr_s(wa_wr_s), .wa_rd_s(wa_rd_s), .wa_addr(wa_addr), .wa_wdata(wa_wdata),
      .wa_rdata(wa_rdata), .wa_ack(wa_ack), .wa_err(wa_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Shared memory: registered read, cleared by reset.
   logic [DATA_W-1:0] mem_arr [8];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) mem_arr[i] <= '0;
         mem_rdata <= '0;
      end else if (mem_en) begin
         if (mem_we) mem_arr[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem_arr[mem_addr];
      end
   end

   typedef struct {
      int          port;
      logic [1:0]  op;
      logic [2:0]  addr;
      logic [15:0] wdata;
      int          lat;
      logic        err;
      int          men;
      logic [15:0] xa_rd;
      logic [15:0] wa_rd;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int p, input logic [1:0] op, input logic [2:0] a, input logic [15:0] d);
      if (p == 0) begin
         {xa_wr_s, xa_rd_s} = op; xa_addr = a; xa_wdata = d;
      end else begin
         {wa_wr_s, wa_rd_s} = op; wa_addr = a; wa_wdata = d;
      end
   endtask

   function automatic logic ack_of(input int p);
      return (p == 0) ? xa_ack : wa_ack;
   endfunction

   function automatic logic err_of(input int p);
      return (p == 0) ? xa_err : wa_err;
   endfunction

   function automatic logic [15:0] rd_of(input int p);
      return (p == 0) ? xa_rdata : wa_rdata;
   endfunction

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " ctl"}, {mem_en, mem_we, xa_ack, wa_ack, xa_err, wa_err}, 0);
      chk({tag, " mem_addr"}, mem_addr, 0);
      chk({tag, " mem_wdata"}, mem_wdata, 0);
      chk({tag, " xa_rdata"}, xa_rdata, 0);
      chk({tag, " wa_rdata"}, wa_rdata, 0);
   endtask

   // Transaction-level reference state for random traffic.
   logic [15:0] model_mem [8];
   bit          pend   [2];
   logic [1:0]  rop    [2];
   logic [2:0]  raddr  [2];
   logic [15:0] rwd    [2];
   int          waitc  [2];
   logic [15:0] exp_rd [2];

   initial begin
      int          ack_port [$];
      int          ack_time [$];
      int          n, men, extra;
      logic        got, other, ok;
      logic [1:0]  acked;

      rst = 1'b1;
      drive(0, 2'b00, 0, 0);
      drive(1, 2'b00, 0, 0);
      repeat (3) tick();
      rst = 1'b0;
      chk_reset_outputs("reset");

      // Both ports READ from reset, strobes held: XA, WA, XA, WA, no bubble.
      drive(0, 2'b01, 3'd1, 0);
      drive(1, 2'b01, 3'd2, 0);
      for (int c = 0; c < 40 && ack_port.size() < 4; c++) begin
         tick();
         if (xa_ack) begin ack_port.push_back(0); ack_time.push_back(c); end
         if (wa_ack) begin ack_port.push_back(1); ack_time.push_back(c); end
      end
      drive(0, 2'b00, 0, 0);
      drive(1, 2'b00, 0, 0);
      chk("rr ack count", ack_port.size(), 4);
      for (int k = 0; k < ack_port.size() && k < 4; k++) begin
         chk($sformatf("rr grant %0d", k), ack_port[k], k % 2);
         if (k > 0) chk($sformatf("rr spacing %0d", k), ack_time[k] - ack_time[k-1], 4);
      end
      repeat (3) tick();

      vecs[0] = '{0, 2'b10, 3'd3, 16'hA5A5, 2, 1'b0, 1, 16'h0000, 16'h0000};
      vecs[1] = '{0, 2'b01, 3'd3, 16'h0000, 3, 1'b0, 1, 16'hA5A5, 16'h0000};
      vecs[2] = '{1, 2'b11, 3'd5, 16'h7777, 1, 1'b1, 0, 16'hA5A5, 16'h0000};
      vecs[3] = '{1, 2'b10, 3'd0, 16'h1234, 2, 1'b0, 1, 16'hA5A5, 16'h0000};
      vecs[4] = '{1, 2'b01, 3'd0, 16'h0000, 3, 1'b0, 1, 16'hA5A5, 16'h1234};
      vecs[5] = '{0, 2'b11, 3'd2, 16'h5555, 1, 1'b1, 0, 16'hA5A5, 16'h1234};
      vecs[6] = '{0, 2'b01, 3'd0, 16'h0000, 3, 1'b0, 1, 16'h1234, 16'h1234};
      vecs[7] = '{1, 2'b01, 3'd3, 16'h0000, 3, 1'b0, 1, 16'h1234, 16'hA5A5};
      vecs[8] = '{0, 2'b10, 3'd7, 16'hBEEF, 2, 1'b0, 1, 16'h1234, 16'hA5A5};
      vecs[9] = '{0, 2'b01, 3'd7, 16'h0000, 3, 1'b0, 1, 16'hBEEF, 16'hA5A5};

      for (int i = 0; i < 10; i++) begin
         n = 0; men = 0; got = 1'b0; other = 1'b0;
         drive(vecs[i].port, vecs[i].op, vecs[i].addr, vecs[i].wdata);
         for (int c = 1; c <= 10 && !got; c++) begin
            tick();
            if (mem_en) begin
               men++;
               chk($sformatf("vec%0d mem_en timing", i), c, 1);
               chk($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].addr);
               chk($sformatf("vec%0d mem_we", i), mem_we, vecs[i].op == 2'b10);
               if (vecs[i].op == 2'b10) chk($sformatf("vec%0d mem_wdata", i), mem_wdata, vecs[i].wdata);
            end
            if (xa_ack || wa_ack) begin
               got = 1'b1;
               n = c;
               other = ack_of(1 - vecs[i].port);
            end
         end
         chk($sformatf("vec%0d ack seen", i), got, 1);
         chk($sformatf("vec%0d latency", i), n, vecs[i].lat);
         chk($sformatf("vec%0d err", i), err_of(vecs[i].port), vecs[i].err);
         chk($sformatf("vec%0d other ack", i), other, 0);
         chk($sformatf("vec%0d xa_rdata", i), xa_rdata, vecs[i].xa_rd);
         chk($sformatf("vec%0d wa_rdata", i), wa_rdata, vecs[i].wa_rd);
         chk($sformatf("vec%0d mem_en count", i), men, vecs[i].men);
         tick();
         chk($sformatf("vec%0d ack pulse", i), ack_of(vecs[i].port), 0);
         drive(vecs[i].port, 2'b00, 0, 0);
         repeat (2) tick();
      end

      // XA keeps its write strobe one cycle past the ack: one access only.
      men = 0; got = 1'b0; extra = 0;
      drive(0, 2'b10, 3'd6, 16'h0F0F);
      for (int c = 0; c < 10 && !got; c++) begin
         tick();
         if (mem_en) men++;
         got = xa_ack;
      end
      chk("held ack seen", got, 1);
      repeat (2) tick();
      drive(0, 2'b00, 0, 0);
      for (int c = 0; c < 6; c++) begin
         tick();
         if (mem_en) men++;
         if (xa_ack) extra++;
      end
      chk("held mem_en count", men, 1);
      chk("held extra acks", extra, 0);

      // Reset while an XA read sits in RDWAIT.
      drive(0, 2'b01, 3'd3, 0);
      tick();
      chk("midrst mem_en", mem_en, 1);
      tick();
      chk("midrst no ack yet", xa_ack, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(0, 2'b00, 0, 0);
      chk_reset_outputs("midrst");
      extra = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (xa_ack || wa_ack || mem_en) extra++;
      end
      chk("midrst quiet", extra, 0);

      // Random traffic against a transaction-level model.
      for (int a = 0; a < 8; a++) model_mem[a] = '0;
      for (int p = 0; p < 2; p++) begin
         pend[p] = 0; waitc[p] = 0; exp_rd[p] = '0;
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         acked = 2'b00;
         chk("rnd single ack", xa_ack & wa_ack, 0);
         if (mem_en) begin
            ok = 1'b0;
            for (int p = 0; p < 2; p++) begin
               if (pend[p] && rop[p] != 2'b11 && raddr[p] == mem_addr &&
                   mem_we == (rop[p] == 2'b10) && (rop[p] != 2'b10 || rwd[p] == mem_wdata))
                  ok = 1'b1;
            end
            chk("rnd mem access matches request", ok, 1);
         end
         for (int p = 0; p < 2; p++) begin
            if (pend[p]) waitc[p]++;
            if (ack_of(p)) begin
               acked[p] = 1'b1;
               if (!pend[p]) begin
                  chk($sformatf("rnd spurious ack p%0d", p), ack_of(p), 0);
               end else begin
                  chk($sformatf("rnd err p%0d", p), err_of(p), rop[p] == 2'b11);
                  if (rop[p] == 2'b01) exp_rd[p] = model_mem[raddr[p]];
                  if (rop[p] == 2'b10) model_mem[raddr[p]] = rwd[p];
                  chk($sformatf("rnd rdata p%0d", p), rd_of(p), exp_rd[p]);
                  chk($sformatf("rnd rdata other p%0d", 1 - p), rd_of(1 - p), exp_rd[1 - p]);
                  pend[p] = 0;
                  drive(p, 2'b00, 0, 0);
               end
            end else if (pend[p] && waitc[p] > 16) begin
               checks++;
               errors++;
               $display("FAIL rnd timeout p%0d: waited %0d cycles, limit 16", p, waitc[p]);
               pend[p] = 0;
               drive(p, 2'b00, 0, 0);
            end
         end
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && !acked[p] && $urandom_range(0, 2) == 0) begin
               rop[p]   = 2'($urandom_range(1, 3));
               raddr[p] = 3'($urandom_range(0, 7));
               rwd[p]   = 16'($urandom);
               pend[p]  = 1;
               waitc[p] = 0;
               drive(p, rop[p], raddr[p], rwd[p]);
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
